difftest_arch_int_reg_shadow: RTL and testbench

- Upstream feeder for the difftest architectural integer register state sink: keeps a 32 x 64-bit shadow of the architectural integer register file, updated from per-lane ROB commit writeback information.
- Drives the sink's enable and 32 values as one registered snapshot after every cycle with commits, on explicit request, and on a periodic heartbeat.
- Simulation/difftest only, per core, sits between the commit stage and the DPI sink.

---
 rtl/difftest_arch_int_reg_shadow.sv | 110 +++++++++++
 tb/tb_difftest_arch_int_reg_shadow.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/difftest_arch_int_reg_shadow.sv
// ---------------------------------------------------------------------------
// difftest_arch_int_reg_shadow
//
// Keeps a 32 x 64-bit shadow of the architectural integer register file,
// updated from the per-lane ROB commit writeback bus. It presents the shadow
// to the difftest integer register sink as a registered snapshot. A snapshot
// is emitted the cycle after:
//   - any commit,
//   - an explicit snapshot request,
//   - a heartbeat timeout,
//   - the first cycle out of reset (boot).
//
// Ports
//   clock          core clock
//   reset          asynchronous, active-high reset
//   io_coreid      core id, registered into out_coreid
//   commit_valid   per-lane commit valid            [COMMIT_WIDTH]
//   commit_wen     per-lane integer write enable    [COMMIT_WIDTH]
//   commit_waddr   per-lane destination, lane i at [5i+4:5i]
//   commit_wdata   per-lane write data,  lane i at [64i+63:64i]
//   snapshot_req   force a snapshot next cycle
//   out_enable     snapshot valid this cycle (sink enable)
//   out_value      shadow register r at [64r+63:64r]
//   out_coreid     registered core id
//
// Handshake: out_enable is a valid-only strobe. There is no ready because
// the sink always accepts. Each cycle with out_enable=1 carries exactly one
// snapshot. Enable sources that coincide in one cycle merge into that single
// pulse, and nothing is queued for a later cycle.
// ---------------------------------------------------------------------------
module difftest_arch_int_reg_shadow #(
    parameter int COMMIT_WIDTH     = 6,
    parameter int HEARTBEAT_CYCLES = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 io_coreid,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid,
    input  logic [COMMIT_WIDTH-1:0]    commit_wen,
    input  logic [5*COMMIT_WIDTH-1:0]  commit_waddr,
    input  logic [64*COMMIT_WIDTH-1:0] commit_wdata,
    input  logic                       snapshot_req,
    output logic                       out_enable,
    output logic [2047:0]              out_value,
    output logic [7:0]                 out_coreid
);

    // The counter only has to reach HEARTBEAT_CYCLES-1.
    // Keep at least one bit so the disabled case still elaborates.
    localparam int CNT_W = (HEARTBEAT_CYCLES == 0) ? 1 : $clog2(HEARTBEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] HB_LAST =
        (HEARTBEAT_CYCLES == 0) ? '0 : CNT_W'(HEARTBEAT_CYCLES - 1);

    logic [31:0][63:0] shadow_q;
    logic [31:0][63:0] shadow_d;
    logic [CNT_W-1:0]  hb_cnt_q;
    logic [CNT_W-1:0]  hb_cnt_d;
    logic              boot_q;
    logic              other_src;
    logic              hb_fire;
    logic              enable_d;

    // Lanes are walked in ascending order, so the highest-numbered writer to
    // an address wins. x0 is never written, so entry 0 stays at its reset 0.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i] && commit_wen[i] && (commit_waddr[5*i +: 5] != 5'd0)) begin
                shadow_d[commit_waddr[5*i +: 5]] = commit_wdata[64*i +: 64];
            end
        end
    end

    // Valid-only lanes (wen=0) still count as commits here.
    always_comb begin
        other_src = (|commit_valid) | snapshot_req | boot_q;
        hb_fire   = (HEARTBEAT_CYCLES != 0) && !other_src && (hb_cnt_q == HB_LAST);
        enable_d  = other_src | hb_fire;
    end

    // Any scheduled snapshot restarts the idle count.
    // This also covers the heartbeat itself, so the counter never passes
    // HB_LAST and never wraps.
    always_comb begin
        if ((HEARTBEAT_CYCLES == 0) || enable_d) begin
            hb_cnt_d = '0;
        end else begin
            hb_cnt_d = hb_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q   <= '0;
            hb_cnt_q   <= '0;
            boot_q     <= 1'b1;
            out_enable <= 1'b0;
            out_coreid <= 8'd0;
        end else begin
            shadow_q   <= shadow_d;
            hb_cnt_q   <= hb_cnt_d;
            boot_q     <= 1'b0;
            out_enable <= enable_d;
            out_coreid <= io_coreid;
        end
    end

    assign out_value = shadow_q;

endmodule

// File: tb/tb_difftest_arch_int_reg_shadow.sv
// ---------------------------------------------------------------------------
// Directed bench for difftest_arch_int_reg_shadow.
// It uses COMMIT_WIDTH=6 and HEARTBEAT_CYCLES=8.
//
// "Cycle c" is the interval after the c-th rising edge following reset
// release. Cycle 0 is the interval in which reset drops.
// Outputs are sampled 1 ns after each rising edge.
// Inputs set in cycle c take effect at the edge that ends cycle c.
// ---------------------------------------------------------------------------
module tb_difftest_arch_int_reg_shadow;

    localparam int CW = 6;
    localparam int HB = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        io_coreid;
    logic [CW-1:0]     commit_valid;
    logic [CW-1:0]     commit_wen;
    logic [5*CW-1:0]   commit_waddr;
    logic [64*CW-1:0]  commit_wdata;
    logic              snapshot_req;
    logic              out_enable;
    logic [2047:0]     out_value;
    logic [7:0]        out_coreid;

    logic [63:0] exp_regs [32];
    logic [63:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    difftest_arch_int_reg_shadow #(
        .COMMIT_WIDTH    (CW),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_coreid   (io_coreid),
        .commit_valid(commit_valid),
        .commit_wen  (commit_wen),
        .commit_waddr(commit_waddr),
        .commit_wdata(commit_wdata),
        .snapshot_req(snapshot_req),
        .out_enable  (out_enable),
        .out_value   (out_value),
        .out_coreid  (out_coreid)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 32; r++) begin
            check($sformatf("%s_x%0d", tag, r), out_value[64*r +: 64], exp_regs[r]);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        commit_valid = '0;
        commit_wen   = '0;
        commit_waddr = '0;
        commit_wdata = '0;
        snapshot_req = 1'b0;
    endtask

    task automatic drive_lane(input int lane, input logic valid, input logic wen,
                              input logic [4:0] addr, input logic [63:0] data);
        commit_valid[lane]         = valid;
        commit_wen[lane]           = wen;
        commit_waddr[5*lane +: 5]  = addr;
        commit_wdata[64*lane +: 64] = data;
    endtask

    task automatic clear_exp();
        for (int r = 0; r < 32; r++) exp_regs[r] = 64'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        io_coreid = 8'h3C;
        clear_inputs();
        clear_exp();

        // Reset state.
        repeat (3) next_cycle();
        check("rst_en", 64'(out_enable), 64'd0);
        check("rst_coreid", 64'(out_coreid), 64'd0);
        check_regs("rst");

        // Release reset with idle inputs.
        // Expect the boot pulse in cycle 1, then heartbeats in cycles 9 and 17.
        reset = 1'b0;                                   // cycle 0
        next_cycle();                                   // cycle 1
        check("boot_en", 64'(out_enable), 64'd1);
        check("coreid_3c", 64'(out_coreid), 64'h3C);
        check_regs("boot");
        for (int c = 2; c <= 17; c++) begin
            next_cycle();
            check($sformatf("hb_en_c%0d", c), 64'(out_enable), 64'(c == 9 || c == 17));
        end

        // Cycle 17: lane0 writes x5. Core id also changes.
        drive_lane(0, 1'b1, 1'b1, 5'd5, 64'h1111_2222_3333_4444);
        io_coreid = 8'hA5;
        next_cycle();                                   // cycle 18
        clear_inputs();
        exp_regs[5] = 64'h1111_2222_3333_4444;
        check("x5_en", 64'(out_enable), 64'd1);
        check("coreid_a5", 64'(out_coreid), 64'hA5);
        check_regs("x5");

        // Cycle 18: lanes 1 and 3 write x10 and lane 3 wins.
        // Lane 2 attempts to write x0.
        drive_lane(1, 1'b1, 1'b1, 5'd10, 64'hAA);
        drive_lane(2, 1'b1, 1'b1, 5'd0,  64'hFF);
        drive_lane(3, 1'b1, 1'b1, 5'd10, 64'hBB);
        next_cycle();                                   // cycle 19
        clear_inputs();
        exp_regs[10] = 64'hBB;
        check("x10_en", 64'(out_enable), 64'd1);
        check_regs("x10");

        // Idle cycles 19..21 bring the heartbeat count to 3 by cycle 22.
        for (int c = 20; c <= 22; c++) begin
            next_cycle();
            check($sformatf("idle_en_c%0d", c), 64'(out_enable), 64'd0);
        end

        // Cycle 22: lane0 has valid=1 and wen=0, plus snapshot_req.
        // Expect one pulse and no write. The count restarts, so the next
        // heartbeat lands in cycle 31 instead of cycle 27.
        drive_lane(0, 1'b1, 1'b0, 5'd7, 64'hDEAD_BEEF_0000_0001);
        snapshot_req = 1'b1;
        next_cycle();                                   // cycle 23
        clear_inputs();
        check("req_en", 64'(out_enable), 64'd1);
        check_regs("req");
        for (int c = 24; c <= 31; c++) begin
            next_cycle();
            check($sformatf("hb2_en_c%0d", c), 64'(out_enable), 64'(c == 31));
        end

        // Cycle 31: lane4 has valid=1 and wen=0 alone.
        // Expect a pulse and an unchanged shadow.
        drive_lane(4, 1'b1, 1'b0, 5'd3, 64'h99);
        next_cycle();                                   // cycle 32
        clear_inputs();
        check("nowen_en", 64'(out_enable), 64'd1);
        check_regs("nowen");

        // Cycles 32..35: x1 is written with 1, 2, 3, 4.
        // Lane5 holds wen=1 without valid and must be ignored.
        for (int v = 1; v <= 4; v++) begin
            drive_lane(0, 1'b1, 1'b1, 5'd1, 64'(v));
            drive_lane(5, 1'b0, 1'b1, 5'd1, 64'hEE);
            exp_q.push_back(64'(v));
            next_cycle();
            check($sformatf("burst_en_%0d", v), 64'(out_enable), 64'd1);
            check($sformatf("burst_x1_%0d", v), out_value[64 +: 64], exp_q.pop_front());
        end
        clear_inputs();
        exp_regs[1] = 64'd4;
        next_cycle();                                   // cycle 37
        check("post_burst_en", 64'(out_enable), 64'd0);
        check_regs("post_burst");

        // Cycle 37: x7 = 0xDEAD. Reset is then asserted mid-burst.
        drive_lane(2, 1'b1, 1'b1, 5'd7, 64'hDEAD);
        next_cycle();                                   // cycle 38
        clear_inputs();
        exp_regs[7] = 64'hDEAD;
        check("x7_en", 64'(out_enable), 64'd1);
        check("x7_val", out_value[64*7 +: 64], 64'hDEAD);
        drive_lane(0, 1'b1, 1'b1, 5'd8, 64'h1234);
        #2 reset = 1'b1;
        #1;
        clear_exp();
        check("rst_mid_en", 64'(out_enable), 64'd0);
        check("rst_mid_coreid", 64'(out_coreid), 64'd0);
        check("rst_mid_x7", out_value[64*7 +: 64], 64'd0);

        // Commits presented while reset is held must be discarded.
        drive_lane(1, 1'b1, 1'b1, 5'd9, 64'h55);
        repeat (2) next_cycle();
        check_regs("in_rst");
        clear_inputs();
        reset = 1'b0;                                   // cycle 0'
        next_cycle();                                   // cycle 1'
        check("reboot_en", 64'(out_enable), 64'd1);
        check_regs("reboot");
        next_cycle();                                   // cycle 2'
        check("reboot_en_c2", 64'(out_enable), 64'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
